// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and a registered ALU: decodes ALUOp/funct,
// drives the ALU for one operation and returns its result over valid/ready.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic        is_branch,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_taken,
    output logic        rsp_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_SUB = 4'b0110;
    localparam logic [3:0] CODE_SLT = 4'b0111;
    localparam logic [3:0] CODE_NOR = 4'b1100;
    localparam logic [3:0] CODE_ILL = 4'b1111;

    logic [1:0]  state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic        branch_q, branch_d;
    logic        illegal_q, illegal_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_taken_q, rsp_taken_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic [3:0]  dec_code;
    logic        dec_illegal;
    logic [31:0] op_b;
    logic [31:0] iss_in1;
    logic [31:0] iss_in2;
    logic        accept;

    always_comb begin
        dec_code    = CODE_ILL;
        dec_illegal = 1'b1;
        case (alu_op)
            2'b00: begin
                dec_code    = CODE_ADD;
                dec_illegal = 1'b0;
            end
            2'b01: begin
                dec_code    = CODE_SUB;
                dec_illegal = 1'b0;
            end
            2'b10: begin
                dec_illegal = 1'b0;
                case (funct)
                    6'b100000: dec_code = CODE_ADD;
                    6'b100010: dec_code = CODE_SUB;
                    6'b100100: dec_code = CODE_AND;
                    6'b100101: dec_code = CODE_OR;
                    6'b101010: dec_code = CODE_SLT;
                    6'b100111: dec_code = CODE_NOR;
                    default: begin
                        dec_code    = CODE_ILL;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_code    = CODE_ILL;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // The ALU's slt reports in2 < in1, so swap operands to get rs < second operand.
    always_comb begin
        op_b = alu_src ? imm : rt_data;
        if (dec_code == CODE_SLT) begin
            iss_in1 = op_b;
            iss_in2 = rs_data;
        end else begin
            iss_in1 = rs_data;
            iss_in2 = op_b;
        end
    end

    assign req_ready = (state_q == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        branch_d      = branch_q;
        illegal_d     = illegal_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ctrl_d    = dec_code;
                    in1_d     = iss_in1;
                    in2_d     = iss_in2;
                    branch_d  = is_branch;
                    illegal_d = dec_illegal;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                rsp_result_d  = alu_result;
                rsp_zero_d    = alu_zero;
                rsp_taken_d   = branch_q && (ctrl_q == CODE_SUB) && alu_zero && !illegal_q;
                rsp_illegal_d = illegal_q;
                rsp_valid_d   = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ctrl_q        <= 4'b0000;
            in1_q         <= 32'd0;
            in2_q         <= 32'd0;
            branch_q      <= 1'b0;
            illegal_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_zero_q    <= 1'b0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            branch_q      <= branch_d;
            illegal_q     <= illegal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_control = ctrl_q;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_taken   = rsp_taken_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: models the registered ALU, drives directed and
// random requests, and scoreboards every response against a reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alu_src;
    logic        is_branch;
    logic [3:0]  alu_control;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_result = 32'd0;
    logic        alu_zero = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_taken;
    logic        rsp_illegal;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] result;
        logic        zero;
        logic        taken;
        logic        illegal;
        int          acceptCyc;
    } expT;

    expT  sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   holdLow = 1'b0;
    bit   prevValid = 1'b0;
    int   riseCyc = 0;
    int   txnNum = 0;
    logic [5:0] fnList [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .alu_op(alu_op), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_src(alu_src), .is_branch(is_branch),
        .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The external ALU: registered, one edge of latency, slt reports in2 < in1.
    function automatic logic [31:0] aluModel(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(b) < $signed(a)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_result <= aluModel(alu_control, alu_in1, alu_in2);
        alu_zero   <= (aluModel(alu_control, alu_in1, alu_in2) == 32'd0);
    end

    // Instruction-level meaning of a request, independent of how the ALU is wired.
    function automatic expT refModel(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [31:0] im, input logic src,
                                     input logic br, input int k);
        expT e;
        logic [31:0] b;
        string kind;
        b = src ? im : rt;
        if (op == 2'b00) kind = "add";
        else if (op == 2'b01) kind = "sub";
        else if (op == 2'b10) begin
            case (fn)
                6'h20: kind = "add";
                6'h22: kind = "sub";
                6'h24: kind = "and";
                6'h25: kind = "or";
                6'h2a: kind = "slt";
                6'h27: kind = "nor";
                default: kind = "ill";
            endcase
        end else kind = "ill";
        e.in1 = rs;
        e.in2 = b;
        e.illegal = 1'b0;
        case (kind)
            "add": begin e.code = 4'b0010; e.result = rs + b; end
            "sub": begin e.code = 4'b0110; e.result = rs - b; end
            "and": begin e.code = 4'b0000; e.result = rs & b; end
            "or":  begin e.code = 4'b0001; e.result = rs | b; end
            "nor": begin e.code = 4'b1100; e.result = ~(rs | b); end
            "slt": begin
                e.code = 4'b0111;
                e.result = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
                e.in1 = b;
                e.in2 = rs;
            end
            default: begin e.code = 4'b1111; e.result = 32'd0; e.illegal = 1'b1; end
        endcase
        e.zero = (e.result == 32'd0);
        e.taken = br && (kind == "sub") && e.zero;
        e.acceptCyc = k;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rsp_ready = holdLow ? 1'b0 : (($urandom % 4) != 0);
    end

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (rsp_valid && !prevValid) begin
                riseCyc = cyc;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResponse: got rsp_valid=1, expected 0 at cycle %0d", cyc);
                end
            end
            if (rsp_valid && rsp_ready && sbq.size() != 0) begin
                expT e;
                e = sbq.pop_front();
                checkOutput($sformatf("t%0d.result", txnNum), rsp_result, e.result);
                checkOutput($sformatf("t%0d.zero", txnNum), 32'(rsp_zero), 32'(e.zero));
                checkOutput($sformatf("t%0d.taken", txnNum), 32'(rsp_taken), 32'(e.taken));
                checkOutput($sformatf("t%0d.illegal", txnNum), 32'(rsp_illegal), 32'(e.illegal));
                checkOutput($sformatf("t%0d.aluControl", txnNum), 32'(alu_control), 32'(e.code));
                checkOutput($sformatf("t%0d.aluIn1", txnNum), alu_in1, e.in1);
                checkOutput($sformatf("t%0d.aluIn2", txnNum), alu_in2, e.in2);
                checkOutput($sformatf("t%0d.latency", txnNum), 32'(riseCyc), 32'(e.acceptCyc + 3));
                txnNum++;
            end
            prevValid = rsp_valid;
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] im, input logic src,
                                 input logic br, input bit track);
        int waitCnt = 0;
        @(negedge clk);
        while (!req_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL reqReadyTimeout: got req_ready=0, expected 1 within 100 cycles");
            return;
        end
        alu_op = op; funct = fn; rs_data = rs; rt_data = rt; imm = im;
        alu_src = src; is_branch = br; req_valid = 1'b1;
        if (track) sbq.push_back(refModel(op, fn, rs, rt, im, src, br, cyc));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        alu_op = 2'($urandom); funct = 6'($urandom); rs_data = $urandom; rt_data = $urandom;
        imm = $urandom; alu_src = 1'($urandom); is_branch = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainTimeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".rspResult"}, rsp_result, 32'd0);
        checkOutput({tag, ".rspZero"}, 32'(rsp_zero), 32'd0);
        checkOutput({tag, ".rspTaken"}, 32'(rsp_taken), 32'd0);
        checkOutput({tag, ".rspIllegal"}, 32'(rsp_illegal), 32'd0);
        checkOutput({tag, ".aluControl"}, 32'(alu_control), 32'd0);
        checkOutput({tag, ".aluIn1"}, alu_in1, 32'd0);
        checkOutput({tag, ".aluIn2"}, alu_in2, 32'd0);
        checkOutput({tag, ".reqReady"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        expT bp;
        int n;
        rst_n = 1'b0; req_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
        rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0; alu_src = 1'b0; is_branch = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset.reqReadyAfter", 32'(req_ready), 32'd1);

        $display("[TB] directed operations");
        applyStimulus(2'b10, 6'b100000, 32'd7, -32'sd3, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b01, 6'd0, 32'h55, 32'h55, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b01, 6'd0, 32'h55, 32'h56, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b10, 6'b101010, -32'sd5, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b10, 6'b101010, 32'd2, -32'sd5, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 6'd0, 32'h1000, 32'd0, -32'sd4, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b11, 6'b100000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);
        drain();

        $display("[TB] illegal funct with backpressure");
        holdLow = 1'b1;
        @(posedge clk);
        #2;
        applyStimulus(2'b10, 6'b000011, 32'd12, 32'd34, 32'd0, 1'b0, 1'b0, 1'b1);
        bp = sbq[0];
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp.rspValidSeen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d.rspValid", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("bp%0d.rspResult", i), rsp_result, bp.result);
            checkOutput($sformatf("bp%0d.rspIllegal", i), 32'(rsp_illegal), 32'd1);
            checkOutput($sformatf("bp%0d.reqReady", i), 32'(req_ready), 32'd0);
            checkOutput($sformatf("bp%0d.aluControl", i), 32'(alu_control), 32'hf);
            if (i == 1) begin
                alu_op = 2'b10; funct = 6'b100000; rs_data = 32'd1; rt_data = 32'd1;
                alu_src = 1'b0; is_branch = 1'b0; req_valid = 1'b1;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        holdLow = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("[TB] async reset while capturing");
        applyStimulus(2'b10, 6'b100000, 32'd100, 32'd23, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("postReset.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("postReset.reqReady", 32'(req_ready), 32'd1);

        $display("[TB] random operations");
        for (int t = 0; t < 80; t++) begin
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] rs, rt, im;
            logic        src, br;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom % 8 < 6) ? fnList[$urandom % 6] : 6'($urandom);
            rs = ($urandom % 3 == 0) ? ($urandom % 8) : $urandom;
            rt = ($urandom % 4 == 0) ? rs : (($urandom % 2 == 0) ? ($urandom % 8) : $urandom);
            im = ($urandom % 2 == 0) ? 32'($signed($urandom % 64) - 32) : $urandom;
            src = 1'($urandom);
            br = (op == 2'b01) ? 1'b1 : 1'($urandom);
            applyStimulus(op, fn, rs, rt, im, src, br, 1'b1);
        end
        drain();
        repeat (3) @(negedge clk);
        checkOutput("final.scoreboardEmpty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
